// File: rtl/ysyx_24100012_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_24100012_lsu -- RV32 load/store unit in front of ysyx_24100012_ram.
//
// One request is taken from the execute stage per transaction. It is checked
// for funct3 legality and alignment, turned into RAM strobes/length/address/
// data, and the LSB-aligned read data is sign/zero-extended. The result goes
// to writeback over a second valid/ready handshake.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   in_wen, in_ren        store / load request
//   in_funct3             000 B, 001 H, 010 W, 100 BU, 101 HU
//   in_addr, in_wdata     byte address, LSB-aligned store data
//   mem_wen, mem_ren      RAM write / read strobes
//   mem_len               access length in bytes (1, 2 or 4)
//   mem_waddr, mem_raddr  RAM write / read address
//   mem_wdata             RAM write data, bytes above mem_len forced to 0
//   mem_rdata             RAM read data, LSB-aligned
//   out_valid / out_ready result handshake
//   out_rdata             extended load data, 0 for stores and errors
//   out_err               misaligned or illegal request
// ---------------------------------------------------------------------------
module ysyx_24100012_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic                  in_ren,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_len,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t          r_state;
  logic            r_ren;
  logic [2:0]      r_funct3;
  logic [3:0]      r_wait_cnt;

  logic            w_hs;
  logic            w_err;
  logic            w_mem_op;

  // Request legality: conflicting strobes, reserved funct3 codes, unsigned
  // stores, and halfword/word accesses that are not naturally aligned.
  function automatic logic f_req_err(input logic       wen,
                                     input logic       ren,
                                     input logic [2:0] f3,
                                     input logic [1:0] a);
    logic bad_code;
    logic store_unsigned;
    logic misalign;
    bad_code       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    store_unsigned = wen & f3[2];
    case (f3[1:0])
      2'b01:   misalign = a[0];
      2'b10:   misalign = (a != 2'b00);
      default: misalign = 1'b0;
    endcase
    return (wen & ren) | bad_code | store_unsigned | misalign;
  endfunction

  // Byte length of the access from the size field of funct3.
  function automatic logic [DATA_WIDTH-1:0] f_len(input logic [1:0] sz);
    case (sz)
      2'b00:   return DATA_WIDTH'(32'd1);
      2'b01:   return DATA_WIDTH'(32'd2);
      2'b10:   return DATA_WIDTH'(32'd4);
      default: return {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  // Keep only the bytes covered by the access; the rest go out as 0.
  function automatic logic [DATA_WIDTH-1:0] f_mask(input logic [1:0]            sz,
                                                   input logic [DATA_WIDTH-1:0] d);
    case (sz)
      2'b00:   return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      2'b01:   return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // RV32 load extension of LSB-aligned RAM data.
  function automatic logic [DATA_WIDTH-1:0] f_extend(input logic [2:0]            f3,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b001:  return {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      3'b010:  return d;
      default: return {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  // in_ready is purely a function of state, so there is no path from out_ready.
  assign in_ready = (r_state == S_IDLE);
  assign w_hs     = in_valid & in_ready;
  assign w_err    = f_req_err(in_wen, in_ren, in_funct3, in_addr[1:0]);
  assign w_mem_op = in_wen | in_ren;

  // Transaction FSM; every RAM-side and result output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ren      <= 1'b0;
      r_funct3   <= 3'b000;
      r_wait_cnt <= 4'd0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
      mem_len    <= {DATA_WIDTH{1'b0}};
      mem_waddr  <= {ADDR_WIDTH{1'b0}};
      mem_raddr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata  <= {DATA_WIDTH{1'b0}};
      out_valid  <= 1'b0;
      out_rdata  <= {DATA_WIDTH{1'b0}};
      out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_ren    <= in_ren;
            r_funct3 <= in_funct3;
            if (w_err || !w_mem_op) begin
              // Nothing to do in RAM: answer straight away, no strobe.
              r_state   <= S_RESP;
              out_valid <= 1'b1;
              out_err   <= w_err;
              out_rdata <= {DATA_WIDTH{1'b0}};
            end else begin
              // Loading the RAM-side registers here makes them the
              // captured request for the whole ACCESS phase.
              r_state    <= S_ACCESS;
              r_wait_cnt <= LAT_INIT;
              mem_wen    <= in_wen;
              mem_ren    <= in_ren;
              mem_len    <= f_len(in_funct3[1:0]);
              mem_waddr  <= in_addr;
              mem_raddr  <= in_addr;
              mem_wdata  <= f_mask(in_funct3[1:0], in_wdata);
            end
          end
        end
        S_ACCESS: begin
          // Write strobe lives for the first ACCESS cycle only.
          mem_wen <= 1'b0;
          if (r_wait_cnt == 4'd0) begin
            r_state   <= S_RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= r_ren ? f_extend(r_funct3, mem_rdata) : {DATA_WIDTH{1'b0}};
            mem_ren   <= 1'b0;
            mem_len   <= {DATA_WIDTH{1'b0}};
            mem_waddr <= {ADDR_WIDTH{1'b0}};
            mem_raddr <= {ADDR_WIDTH{1'b0}};
            mem_wdata <= {DATA_WIDTH{1'b0}};
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            out_rdata <= {DATA_WIDTH{1'b0}};
            out_err   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          mem_wen   <= 1'b0;
          mem_ren   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for ysyx_24100012_lsu. The driver pushes the expected
// response of every accepted request (from a behavioural model of the RV32
// load/store rules) into a queue; an independent monitor watches the RAM
// side and the result port and pops/compares when a result is accepted.
// ---------------------------------------------------------------------------
module tb_ysyx_24100012_lsu;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic        in_ren;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_len;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  ysyx_24100012_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wen    (in_wen),
    .in_ren    (in_ren),
    .in_funct3 (in_funct3),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_len   (mem_len),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rdata (out_rdata),
    .out_err   (out_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          wen_n;
    int          ren_n;
    int          lat;
    int          hs;
    logic [31:0] addr;
    logic [31:0] wdata_m;
    logic [31:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   cyc;
  int   bp_hold;
  int   mon_wen_cnt;
  int   mon_ren_cnt;
  bit   mon_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: what the RV32 rules say the LSU must do with a request.
  function automatic exp_t model(input logic wen, input logic ren, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t    e;
    int      size;
    bit      bad;
    byte     sb;
    shortint sh;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad  = (wen && ren) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
           (wen && (f3 == 3'd4 || f3 == 3'd5)) || ((addr % size) != 0);
    e.addr    = addr;
    e.len     = size;
    e.wdata_m = (size == 4) ? wd : (wd % (32'd1 << (8 * size)));
    e.hs      = 0;
    e.rdata   = 32'd0;
    if (bad || !(wen || ren)) begin
      e.err = bad; e.wen_n = 0; e.ren_n = 0; e.lat = 0;
    end else begin
      e.err = 1'b0; e.lat = LAT + 1;
      e.wen_n = wen ? 1 : 0;
      e.ren_n = ren ? LAT + 1 : 0;
      if (ren) begin
        sb = byte'(rd[7:0]);
        sh = shortint'(rd[15:0]);
        case (f3)
          3'd0:    e.rdata = 32'(int'(sb));
          3'd4:    e.rdata = rd & 32'h0000_00FF;
          3'd1:    e.rdata = 32'(int'(sh));
          3'd5:    e.rdata = rd & 32'h0000_FFFF;
          default: e.rdata = rd;
        endcase
      end
    end
    return e;
  endfunction

  // Result-side backpressure, driven between edges.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid && bp_hold > 0) begin
        out_ready = 1'b0;
        bp_hold--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: RAM side and result side, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() == 0) begin
          chk("idle_no_wen", {31'd0, mem_wen}, 32'd0);
          chk("idle_no_ren", {31'd0, mem_ren}, 32'd0);
          chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q[0];
          if (mem_wen) begin
            mon_wen_cnt++;
            chk("waddr", mem_waddr, e.addr);
            chk("wdata", mem_wdata, e.wdata_m);
            chk("wlen", mem_len, e.len);
          end
          if (mem_ren) begin
            mon_ren_cnt++;
            chk("raddr", mem_raddr, e.addr);
            chk("rlen", mem_len, e.len);
          end
          if (out_valid) begin
            if (!mon_seen) begin
              chk("latency", cyc - e.hs, e.lat);
              mon_seen = 1'b1;
            end
            chk("rdata", out_rdata, e.rdata);
            chk("err", {31'd0, out_err}, {31'd0, e.err});
            chk("in_ready_resp", {31'd0, in_ready}, 32'd0);
            chk("strobe_resp", {31'd0, mem_wen | mem_ren}, 32'd0);
            if (out_ready) begin
              chk("wen_pulses", mon_wen_cnt, e.wen_n);
              chk("ren_cycles", mon_ren_cnt, e.ren_n);
              void'(exp_q.pop_front());
              mon_wen_cnt = 0;
              mon_ren_cnt = 0;
              mon_seen    = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_wen"}, {31'd0, mem_wen}, 32'd0);
    chk({tag, "_mem_ren"}, {31'd0, mem_ren}, 32'd0);
    chk({tag, "_mem_len"}, mem_len, 32'd0);
    chk({tag, "_mem_waddr"}, mem_waddr, 32'd0);
    chk({tag, "_mem_raddr"}, mem_raddr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_rdata"}, out_rdata, 32'd0);
    chk({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Issue one request; while it is in flight, wiggle the request inputs.
  task automatic issue(input logic wen, input logic ren, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int bp, input bit abort);
    exp_t e;
    int   k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    e    = model(wen, ren, f3, addr, wd, rd);
    e.hs = cyc + 1;
    in_valid  = 1'b1;
    in_wen    = wen;
    in_ren    = ren;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wd;
    mem_rdata = rd;
    bp_hold   = bp;
    exp_q.push_back(e);
    @(negedge clk);
    if (abort) begin
      k = 0;
      while (!mem_ren && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("abort_in_access", {31'd0, mem_ren}, 32'd1);
      #1 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      #1 rst = 1'b0;
      exp_q.delete();
      mon_wen_cnt = 0;
      mon_ren_cnt = 0;
      mon_seen    = 1'b0;
      in_valid    = 1'b0;
    end else begin
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_wen    = 1'($urandom_range(0, 1));
        in_ren    = 1'($urandom_range(0, 1));
        in_funct3 = 3'($urandom_range(0, 7));
        in_addr   = $urandom;
        in_wdata  = $urandom;
        @(negedge clk);
        k++;
      end
      if (k >= 200) chk("drain", exp_q.size(), 32'd0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    n_total++;
    $display("FAIL watchdog: run did not finish, %0d results outstanding", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          op;
    n_pass = 0; n_total = 0; bp_hold = 0;
    mon_wen_cnt = 0; mon_ren_cnt = 0; mon_seen = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0; in_wen = 1'b0; in_ren = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases: LB, LHU, LH, SW, SB, misaligned LW, SBU-style store,
    // wen&ren, backpressured LW.
    issue(1'b0, 1'b1, 3'd0, 32'h8000_0003, 32'd0,          32'h0000_00F0, 0, 1'b0);
    issue(1'b0, 1'b1, 3'd5, 32'h8000_0002, 32'd0,          32'h0000_8001, 0, 1'b0);
    issue(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'd0,          32'h0000_8001, 0, 1'b0);
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF,  32'h1111_1111, 0, 1'b0);
    issue(1'b1, 1'b0, 3'd0, 32'h8000_0021, 32'h1234_5678,  32'h0,         0, 1'b0);
    issue(1'b0, 1'b1, 3'd2, 32'h8000_0002, 32'd0,          32'hCAFE_F00D, 0, 1'b0);
    issue(1'b1, 1'b0, 3'd4, 32'h8000_0004, 32'hFFFF_FFFF,  32'h0,         0, 1'b0);
    issue(1'b1, 1'b1, 3'd2, 32'h8000_0008, 32'hA5A5_A5A5,  32'h5A5A_5A5A, 0, 1'b0);
    issue(1'b0, 1'b1, 3'd2, 32'h8000_0008, 32'd0,          32'h8765_4321, 5, 1'b0);

    // Reset in the middle of a load, then a normal load must still work.
    issue(1'b0, 1'b1, 3'd2, 32'h8000_0040, 32'd0,          32'h0BAD_CAFE, 0, 1'b1);
    issue(1'b0, 1'b1, 3'd1, 32'h8000_0042, 32'd0,          32'h0000_7FFE, 0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(op < 4 || op == 8, (op >= 4 && op < 9) ? 1'b0 : (op < 4 || op == 8),
            f3, a, $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 4 : 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
